// File: rtl/seg7_scan_ctrl.sv
// Purpose : time-multiplexed scan of DIGITS common-anode 7-seg digits with a double-buffered image.
// Latency : outputs are registered, 1 cycle behind slot state; a load takes effect at the next frame wrap.
// Backpressure: none; iLOAD is always accepted, last value before a wrap wins, one oLOAD_ACK per wrap.
//
// Ports:
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   iDIG[4*DIGITS-1:0]    nibble per digit (digit k = iDIG[4k+3:4k])
//   iDP, iBLANK           per-digit decimal point request / dark mask
//   iLOAD                 capture strobe for iDIG/iDP/iBLANK
//   oLOAD_ACK             pulse when a captured image becomes active (with oFRAME)
//   oDIG_SEL              active-low one-hot digit enable, all ones when dark
//   oSEG, oSEG_DP         active-low segments (bit0 top .. bit6 middle) and decimal point
//   oFRAME                pulse in the cycle after the scan wraps from digit DIGITS-1 to 0
// Optional: define SEG7_SCAN_DIM_EN to add iBRIGHT[3:0] (duty = iBRIGHT/16 of the drive time).
module seg7_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [4*DIGITS-1:0]   iDIG,
  input  logic [DIGITS-1:0]     iDP,
  input  logic [DIGITS-1:0]     iBLANK,
  input  logic                  iLOAD,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [3:0]            iBRIGHT,
`endif
  output logic                  oLOAD_ACK,
  output logic [DIGITS-1:0]     oDIG_SEL,
  output logic [6:0]            oSEG,
  output logic                  oSEG_DP,
  output logic                  oFRAME
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST     = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(DIGITS - 1);

  typedef enum logic {S_GAP, S_DRIVE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] act_dig, pend_dig;
  logic [DIGITS-1:0]   act_dp, act_blank, pend_dp, pend_blank;
  logic                pend_vld;

  logic                cnt_wrap, frame_wrap, dim_on;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   sel_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h18;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

`ifdef SEG7_SCAN_DIM_EN
  // Brightness compare without a divider: floor((cnt-GAP)*16/LEN) < b  <=>  (cnt-GAP)*16 < b*LEN.
  // dim_acc steps by 16 per drive cycle; dim_thresh = b*LEN is refreshed at each frame wrap.
  localparam int DRIVE_LEN = DWELL_CYCLES - GAP_CYCLES;
  localparam int AW        = $clog2(DRIVE_LEN * 16 + 1);
  logic [AW-1:0] dim_acc, dim_thresh;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dim_acc    <= '0;
      dim_thresh <= '0;
    end else begin
      dim_acc <= (state == S_DRIVE && state_nxt == S_DRIVE) ? dim_acc + AW'(16) : '0;
      if (frame_wrap) dim_thresh <= AW'(iBRIGHT) * AW'(DRIVE_LEN);
    end
  end

  assign dim_on = (dim_acc < dim_thresh);
`else
  assign dim_on = 1'b1;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_GAP;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_wrap   = (cnt == CNT_LAST);
    frame_wrap = cnt_wrap && (idx == IDX_LAST);
    nibble     = act_dig[{idx, 2'b00} +: 4];
    sel_nxt    = '1;
    seg_nxt    = 7'h7F;
    dp_nxt     = 1'b1;

    if (cnt_wrap)                 state_nxt = S_GAP;
    else if (cnt == CNT_GAP_LAST) state_nxt = S_DRIVE;

    if (state == S_DRIVE && !act_blank[idx] && dim_on) begin
      sel_nxt[idx] = 1'b0;
      seg_nxt      = decode(nibble);
      dp_nxt       = ~act_dp[idx];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt        <= '0;
      idx        <= '0;
      act_dig    <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_vld   <= 1'b0;
      oDIG_SEL   <= '1;
      oSEG       <= 7'h7F;
      oSEG_DP    <= 1'b1;
      oFRAME     <= 1'b0;
      oLOAD_ACK  <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

      oDIG_SEL  <= sel_nxt;
      oSEG      <= seg_nxt;
      oSEG_DP   <= dp_nxt;
      oFRAME    <= frame_wrap;
      oLOAD_ACK <= frame_wrap && (iLOAD || pend_vld);

      // A load on the wrap edge bypasses the pending buffer and supersedes it.
      if (frame_wrap) begin
        if (iLOAD) begin
          act_dig   <= iDIG;
          act_dp    <= iDP;
          act_blank <= iBLANK;
        end else if (pend_vld) begin
          act_dig   <= pend_dig;
          act_dp    <= pend_dp;
          act_blank <= pend_blank;
        end
        pend_vld <= 1'b0;
      end else if (iLOAD) begin
        pend_dig   <= iDIG;
        pend_dp    <= iDP;
        pend_blank <= iBLANK;
        pend_vld   <= 1'b1;
      end
    end
  end

endmodule
